// File: rtl/wb_trace_buffer.sv
// Retirement trace buffer for the debug writeback stream.
// Circular capture with PC trigger, post-trigger window and freeze/readout.
module wb_trace_buffer #(
  parameter int DEPTH     = 16,
  parameter int POST_TRIG = 8
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [31:0]              debug_wb_pc,
  input  logic [3:0]               debug_wb_rf_we,
  input  logic [4:0]               debug_wb_rf_wnum,
  input  logic [31:0]              debug_wb_rf_wdata,
  input  logic                     arm,
  input  logic                     trig_en,
  input  logic [31:0]              trig_pc,
  input  logic                     rd_en,
  output logic [68:0]              rd_data,
  output logic                     rd_valid,
  output logic [$clog2(DEPTH):0]   count,
  output logic [1:0]               state,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] P_ONE = 1;
  localparam logic [AW:0]   C_ONE = 1;
  localparam logic [AW:0]   FULL  = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] POST  = AW'(POST_TRIG);

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    ARMED     = 2'b01,
    TRIGGERED = 2'b10,
    FROZEN    = 2'b11
  } st_t;

  st_t           st_q, st_d;
  logic [AW-1:0] post_q, post_d;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [68:0]   mem [DEPTH];
  logic          cap, hit, pop;
  logic [68:0]   entry;

  assign entry = {debug_wb_pc, debug_wb_rf_wnum, debug_wb_rf_wdata};
  assign cap   = (|debug_wb_rf_we) && !arm &&
                 (st_q == ARMED || st_q == TRIGGERED);
  assign hit   = cap && (st_q == ARMED) && trig_en &&
                 (debug_wb_pc == trig_pc);
  assign pop   = rd_en && !arm && (st_q == FROZEN) && (count != '0);
  assign state = st_q;

  always_comb begin
    st_d   = st_q;
    post_d = post_q;
    if (arm) begin
      st_d   = ARMED;
      post_d = '0;
    end else begin
      unique case (st_q)
        ARMED: begin
          if (hit) begin
            post_d = POST;
            st_d   = (POST_TRIG == 0) ? FROZEN : TRIGGERED;
          end
        end
        TRIGGERED: begin
          if (cap) begin
            post_d = post_q - P_ONE;
            if (post_q == P_ONE) st_d = FROZEN;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      st_q   <= IDLE;
      post_q <= '0;
    end else begin
      st_q   <= st_d;
      post_q <= post_d;
    end
  end

  // Storage has no reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (cap) mem[wr_ptr] <= entry;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= pop;
      if (arm) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        count    <= '0;
        overflow <= 1'b0;
      end else if (cap) begin
        wr_ptr <= wr_ptr + P_ONE;
        if (count == FULL) begin
          rd_ptr   <= rd_ptr + P_ONE;
          overflow <= 1'b1;
        end else begin
          count <= count + C_ONE;
        end
      end else if (pop) begin
        rd_data <= mem[rd_ptr];
        rd_ptr  <= rd_ptr + P_ONE;
        count   <= count - C_ONE;
      end
    end
  end

endmodule

// File: tb/tb_wb_trace_buffer.sv
// Directed bench for wb_trace_buffer.
// Two instances: POST_TRIG=8 (main) and POST_TRIG=0 (z).
module tb_wb_trace_buffer;

  logic        clk = 1'b0;
  logic        resetn;
  logic [31:0] pc;
  logic [3:0]  we;
  logic [4:0]  wnum;
  logic [31:0] wdata;
  logic        arm, trig_en, rd_en;
  logic [31:0] trig_pc;

  logic [68:0] rd_data, rd_data_z;
  logic        rd_valid, rd_valid_z;
  logic [4:0]  count, count_z;
  logic [1:0]  state, state_z;
  logic        overflow, overflow_z;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  wb_trace_buffer #(.DEPTH(16), .POST_TRIG(8)) u_dut (
    .clk(clk), .resetn(resetn),
    .debug_wb_pc(pc), .debug_wb_rf_we(we),
    .debug_wb_rf_wnum(wnum), .debug_wb_rf_wdata(wdata),
    .arm(arm), .trig_en(trig_en), .trig_pc(trig_pc),
    .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid),
    .count(count), .state(state), .overflow(overflow)
  );

  wb_trace_buffer #(.DEPTH(16), .POST_TRIG(0)) u_dut_z (
    .clk(clk), .resetn(resetn),
    .debug_wb_pc(pc), .debug_wb_rf_we(we),
    .debug_wb_rf_wnum(wnum), .debug_wb_rf_wdata(wdata),
    .arm(arm), .trig_en(trig_en), .trig_pc(trig_pc),
    .rd_en(rd_en), .rd_data(rd_data_z), .rd_valid(rd_valid_z),
    .count(count_z), .state(state_z), .overflow(overflow_z)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_arm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic retire(input logic [31:0] p, input logic [4:0] n,
                        input logic [31:0] d);
    pc = p; wnum = n; wdata = d; we = 4'b0010;
    tick();
    we = 4'b0000;
  endtask

  task automatic test_reset();
    vecs++;
    if (state !== 2'b00 || count !== 5'd0 || rd_valid !== 1'b0 ||
        rd_data !== 69'd0 || overflow !== 1'b0) begin
      errs++;
      $display("FAIL reset: st=%b cnt=%0d v=%b d=%h ov=%b want 00/0/0/0/0",
               state, count, rd_valid, rd_data, overflow);
    end
  endtask

  task automatic test_reset_mid_capture();
    do_arm();
    for (int i = 0; i < 3; i++) retire(32'h100 + 32'(4*i), 5'(i+1), 32'(i));
    vecs++;
    if (count !== 5'd3) begin
      errs++; $display("FAIL pre_reset_count: got %0d want 3", count);
    end
    #3 resetn = 1'b0;
    #1;
    vecs++;
    if (state !== 2'b00 || count !== 5'd0 || rd_valid !== 1'b0 ||
        overflow !== 1'b0) begin
      errs++;
      $display("FAIL async_reset: st=%b cnt=%0d want 00/0", state, count);
    end
    tick();
    vecs++;
    if (state !== 2'b00 || count !== 5'd0) begin
      errs++;
      $display("FAIL reset_hold: st=%b cnt=%0d want 00/0", state, count);
    end
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_no_trigger();
    int seen = 0;
    trig_en = 1'b0;
    do_arm();
    for (int i = 0; i < 5; i++) begin
      retire(32'h200 + 32'(4*i), 5'(i), 32'hA0 + 32'(i));
      if (rd_valid) seen++;
    end
    tick(); if (rd_valid) seen++;
    tick(); if (rd_valid) seen++;
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    if (rd_valid) seen++;
    tick(); if (rd_valid) seen++;
    vecs++;
    if (count !== 5'd5 || state !== 2'b01) begin
      errs++;
      $display("FAIL armed_count: cnt=%0d st=%b want 5/01", count, state);
    end
    vecs++;
    if (seen !== 0) begin
      errs++; $display("FAIL armed_no_pop: rd_valid seen %0d want 0", seen);
    end
    do_arm();
    vecs++;
    if (count !== 5'd0 || overflow !== 1'b0 || state !== 2'b01) begin
      errs++;
      $display("FAIL rearm: cnt=%0d ov=%b st=%b want 0/0/01",
               count, overflow, state);
    end
  endtask

  task automatic test_trigger_wrap();
    logic [31:0] p;
    logic [68:0] exp;
    trig_en = 1'b1;
    trig_pc = 32'h1c000050;
    do_arm();
    for (int i = 0; i < 30; i++) begin
      p = 32'h1c000000 + 32'(4*i);
      retire(p, 5'(i), 32'hd0000000 + 32'(i));
      if (i == 15) begin
        vecs++;
        if (count !== 5'd16 || overflow !== 1'b0) begin
          errs++;
          $display("FAIL full_no_ovf: cnt=%0d ov=%b want 16/0", count, overflow);
        end
      end
      if (i == 20) begin
        vecs++;
        if (state !== 2'b10) begin
          errs++; $display("FAIL trig_state: st=%b want 10", state);
        end
      end
      if (i == 27) begin
        vecs++;
        if (state !== 2'b10) begin
          errs++; $display("FAIL post_window: st=%b want 10", state);
        end
      end
      if (i == 28) begin
        vecs++;
        if (state !== 2'b11) begin
          errs++; $display("FAIL freeze_state: st=%b want 11", state);
        end
      end
    end
    vecs++;
    if (count !== 5'd16 || overflow !== 1'b1 || state !== 2'b11) begin
      errs++;
      $display("FAIL frozen: cnt=%0d ov=%b st=%b want 16/1/11",
               count, overflow, state);
    end
    rd_en = 1'b1;
    for (int i = 13; i <= 28; i++) begin
      tick();
      exp = {32'h1c000000 + 32'(4*i), 5'(i), 32'hd0000000 + 32'(i)};
      vecs++;
      if (rd_valid !== 1'b1 || rd_data !== exp) begin
        errs++;
        $display("FAIL pop_%0d: v=%b d=%h want 1/%h", i, rd_valid, rd_data, exp);
      end
    end
    rd_en = 1'b0;
    vecs++;
    if (count !== 5'd0) begin
      errs++; $display("FAIL drained: cnt=%0d want 0", count);
    end
    tick();
    vecs++;
    if (rd_valid !== 1'b0 || state !== 2'b11) begin
      errs++;
      $display("FAIL after_drain: v=%b st=%b want 0/11", rd_valid, state);
    end
  endtask

  task automatic test_post_trig_zero();
    trig_en = 1'b1;
    trig_pc = 32'h00003008;
    do_arm();
    retire(32'h00003000, 5'd1, 32'h11);
    retire(32'h00003004, 5'd0, 32'h22);
    retire(32'h00003008, 5'd3, 32'h33);
    vecs++;
    if (state_z !== 2'b11 || count_z !== 5'd3) begin
      errs++;
      $display("FAIL pt0_freeze: st=%b cnt=%0d want 11/3", state_z, count_z);
    end
    retire(32'h0000300c, 5'd4, 32'h44);
    vecs++;
    if (count_z !== 5'd3) begin
      errs++; $display("FAIL pt0_no_cap: cnt=%0d want 3", count_z);
    end
    rd_en = 1'b1;
    tick();
    vecs++;
    if (rd_data_z[68:37] !== 32'h00003000 || rd_data_z[36:32] !== 5'd1) begin
      errs++; $display("FAIL pt0_pop0: pc=%h want 00003000", rd_data_z[68:37]);
    end
    tick();
    vecs++;
    if (rd_data_z !== {32'h00003004, 5'd0, 32'h22}) begin
      errs++; $display("FAIL pt0_pop_r0: d=%h want r0 entry", rd_data_z);
    end
    tick();
    rd_en = 1'b0;
    vecs++;
    if (rd_valid_z !== 1'b1 || rd_data_z[68:37] !== trig_pc) begin
      errs++;
      $display("FAIL pt0_last: v=%b pc=%h want 1/%h",
               rd_valid_z, rd_data_z[68:37], trig_pc);
    end
  endtask

  task automatic test_back_to_back();
    trig_en = 1'b1;
    trig_pc = 32'h00004004;
    do_arm();
    retire(32'h00004000, 5'd7, 32'hCAFE0001);
    retire(32'h00004004, 5'd8, 32'hCAFE0002);
    vecs++;
    if (state_z !== 2'b11 || count_z !== 5'd2) begin
      errs++;
      $display("FAIL b2b_setup: st=%b cnt=%0d want 11/2", state_z, count_z);
    end
    rd_en = 1'b1;
    tick();
    vecs++;
    if (rd_valid_z !== 1'b1 || count_z !== 5'd1 ||
        rd_data_z !== {32'h00004000, 5'd7, 32'hCAFE0001}) begin
      errs++;
      $display("FAIL b2b_0: v=%b cnt=%0d d=%h", rd_valid_z, count_z, rd_data_z);
    end
    tick();
    vecs++;
    if (rd_valid_z !== 1'b1 || count_z !== 5'd0 ||
        rd_data_z !== {32'h00004004, 5'd8, 32'hCAFE0002}) begin
      errs++;
      $display("FAIL b2b_1: v=%b cnt=%0d d=%h", rd_valid_z, count_z, rd_data_z);
    end
    tick();
    rd_en = 1'b0;
    vecs++;
    if (rd_valid_z !== 1'b0 || count_z !== 5'd0 ||
        rd_data_z !== {32'h00004004, 5'd8, 32'hCAFE0002}) begin
      errs++;
      $display("FAIL b2b_empty: v=%b cnt=%0d d=%h want 0/0/held",
               rd_valid_z, count_z, rd_data_z);
    end
  endtask

  task automatic test_arm_with_pop();
    trig_en = 1'b1;
    trig_pc = 32'h00005000;
    do_arm();
    retire(32'h00005000, 5'd9, 32'h99);
    vecs++;
    if (state_z !== 2'b11 || count_z !== 5'd1) begin
      errs++;
      $display("FAIL ap_setup: st=%b cnt=%0d want 11/1", state_z, count_z);
    end
    trig_en = 1'b0;
    arm = 1'b1; rd_en = 1'b1;
    tick();
    arm = 1'b0; rd_en = 1'b0;
    vecs++;
    if (rd_valid_z !== 1'b0 || state_z !== 2'b01 || count_z !== 5'd0) begin
      errs++;
      $display("FAIL arm_pop: v=%b st=%b cnt=%0d want 0/01/0",
               rd_valid_z, state_z, count_z);
    end
    retire(32'h00005004, 5'd10, 32'hAA);
    vecs++;
    if (count_z !== 5'd1 || count !== 5'd1) begin
      errs++;
      $display("FAIL arm_then_cap: cnt=%0d/%0d want 1/1", count_z, count);
    end
  endtask

  initial begin
    resetn = 1'b0;
    pc = '0; we = '0; wnum = '0; wdata = '0;
    arm = 1'b0; trig_en = 1'b0; trig_pc = '0; rd_en = 1'b0;
    #12;
    test_reset();
    resetn = 1'b1;
    tick();
    test_reset_mid_capture();
    test_no_trigger();
    test_trigger_wrap();
    test_post_trig_zero();
    test_back_to_back();
    test_arm_with_pop();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
